biriscv_mulf_unit: RTL and testbench

- Iterative execution unit for the custom MULF instruction: signed Q16.16 fixed-point multiply with round-half-away-from-zero and saturation.
- Sits directly downstream of the instruction decoder: the issue stage routes any instruction flagged mulf to this unit, and the unit returns one writeback per accepted instruction.
- Multi-cycle, one operation in flight; stalls issue while busy.

---
 rtl/biriscv_mulf_unit_pkg.sv | 28 ++
 rtl/biriscv_mulf_unit_round_sat.sv | 28 ++
 rtl/biriscv_mulf_unit.sv | 136 +++++++++++++
 tb/tb_biriscv_mulf_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biriscv_mulf_unit_pkg.sv
// Shared encodings and Q16.16 constants for the MULF execution unit.
package biriscv_mulf_unit_pkg;

   // MULF lives in the custom-0 opcode space: funct7=0000001, funct3=000.
   localparam logic [31:0] INST_MULF      = 32'h0200_000b;
   localparam logic [31:0] INST_MULF_MASK = 32'hfe00_707f;

   typedef enum logic [1:0] {
      MULF_IDLE = 2'd0,
      MULF_RUN  = 2'd1,
      MULF_DONE = 2'd2
   } mulf_state_e;

   localparam int unsigned FRAC_BITS  = 16;
   localparam logic [63:0] ROUND_BIAS = 64'h0000_0000_0000_8000;
   localparam logic [31:0] SAT_POS    = 32'h7fff_ffff;
   localparam logic [31:0] SAT_NEG    = 32'h8000_0000;

   function automatic logic is_mulf(input logic [31:0] inst);
      return (inst & INST_MULF_MASK) == INST_MULF;
   endfunction

   // Magnitude as unsigned; 0x80000000 maps to 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/biriscv_mulf_unit_round_sat.sv
// Rounds a 64-bit Q32.32 magnitude to Q16.16 (half away from zero), applies
// the sign and saturates to the signed 32-bit range.
module biriscv_mulf_round_sat
   import biriscv_mulf_unit_pkg::*;
(
   input  logic [63:0] mag_i,
   input  logic        neg_i,
   output logic [31:0] value_o
);

   logic [63:0] biased_w;
   logic [63:0] rounded_w;

   // Rounding the magnitude before negating gives half-away-from-zero for free.
   always_comb begin
      biased_w  = mag_i + ROUND_BIAS;
      rounded_w = biased_w >> FRAC_BITS;
      value_o   = '0;
      if (!neg_i) begin
         if (rounded_w > {32'd0, SAT_POS}) value_o = SAT_POS;
         else                              value_o = rounded_w[31:0];
      end else begin
         if (rounded_w > {32'd0, SAT_NEG}) value_o = SAT_NEG;
         else                              value_o = ~rounded_w[31:0] + 32'd1;
      end
   end

endmodule

// File: rtl/biriscv_mulf_unit.sv
// Iterative signed Q16.16 multiply unit for MULF: shift-add on magnitudes,
// BITS_PER_CYCLE multiplier bits per iteration, one operation in flight.
module biriscv_mulf_unit
   import biriscv_mulf_unit_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        opcode_valid_i,
   input  logic [31:0] opcode_opcode_i,
   input  logic [31:0] opcode_ra_operand_i,
   input  logic [31:0] opcode_rb_operand_i,
   input  logic [4:0]  opcode_rd_idx_i,
   input  logic        hold_i,
   input  logic        flush_i,
   output logic        writeback_valid_o,
   output logic [31:0] writeback_value_o,
   output logic [4:0]  writeback_rd_idx_o,
   output logic        stall_o
);

   localparam int unsigned ITER  = 32 / BITS_PER_CYCLE;
   localparam int unsigned CNT_W = 6;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   mulf_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [63:0]      acc_q, acc_d;
   logic             neg_q, neg_d;
   logic [4:0]       rd_q, rd_d;
   logic             wb_valid_q, wb_valid_d;
   logic [31:0]      wb_value_q, wb_value_d;
   logic [4:0]       wb_rd_q, wb_rd_d;

   logic [63:0]      partial_w;
   logic [63:0]      acc_sum_w;
   logic [31:0]      result_w;

   // a_q is pre-shifted each iteration, so the partial product needs no offset.
   assign partial_w = a_q * {{(64-BITS_PER_CYCLE){1'b0}}, b_q[BITS_PER_CYCLE-1:0]};
   assign acc_sum_w = acc_q + partial_w;

   biriscv_mulf_round_sat u_round_sat (
      .mag_i   (acc_sum_w),
      .neg_i   (neg_q),
      .value_o (result_w)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      rd_d       = rd_q;
      wb_valid_d = wb_valid_q;
      wb_value_d = wb_value_q;
      wb_rd_d    = wb_rd_q;
      case (state_q)
         MULF_IDLE: begin
            if (opcode_valid_i && !flush_i && is_mulf(opcode_opcode_i)) begin
               a_d     = {32'd0, abs32(opcode_ra_operand_i)};
               b_d     = abs32(opcode_rb_operand_i);
               neg_d   = opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31];
               rd_d    = opcode_rd_idx_i;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MULF_RUN;
            end
         end
         MULF_RUN: begin
            if (flush_i) begin
               state_d = MULF_IDLE;
            end else begin
               acc_d = acc_sum_w;
               a_d   = a_q << BITS_PER_CYCLE;
               b_d   = b_q >> BITS_PER_CYCLE;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_ITER) begin
                  wb_valid_d = 1'b1;
                  wb_value_d = result_w;
                  wb_rd_d    = rd_q;
                  state_d    = MULF_DONE;
               end
            end
         end
         MULF_DONE: begin
            // Flush wins over hold: the result is dropped even if writeback stalls.
            if (flush_i || !hold_i) begin
               wb_valid_d = 1'b0;
               state_d    = MULF_IDLE;
            end
         end
         default: begin
            wb_valid_d = 1'b0;
            state_d    = MULF_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= MULF_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         neg_q      <= 1'b0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_value_q <= '0;
         wb_rd_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         neg_q      <= neg_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_value_q <= wb_value_d;
         wb_rd_q    <= wb_rd_d;
      end
   end

   assign writeback_valid_o  = wb_valid_q;
   assign writeback_value_o  = wb_value_q;
   assign writeback_rd_idx_o = wb_rd_q;
   assign stall_o            = (state_q != MULF_IDLE);

endmodule

// File: tb/tb_biriscv_mulf_unit.sv
// Bench for biriscv_mulf_unit: vector table, random ops against an arithmetic
// model, protocol sequences, and a direct check of the round/saturate block.
module tb_biriscv_mulf_unit;
   import biriscv_mulf_unit_pkg::*;

   localparam logic [31:0] INST_ADD = 32'h0000_0033;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [31:0] op_inst, op_ra, op_rb;
   logic [4:0]  op_rd;
   logic        hold, flush;
   logic        wb_valid, wb_valid1, wb_valid8;
   logic [31:0] wb_value, wb_value1, wb_value8;
   logic [4:0]  wb_rd, wb_rd1, wb_rd8;
   logic        stall, stall1, stall8;
   logic [63:0] rs_mag;
   logic        rs_neg;
   logic [31:0] rs_value;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   biriscv_mulf_unit #(.BITS_PER_CYCLE(4)) dut (
      .clk_i(clk), .rst_i(rst), .opcode_valid_i(op_valid), .opcode_opcode_i(op_inst),
      .opcode_ra_operand_i(op_ra), .opcode_rb_operand_i(op_rb), .opcode_rd_idx_i(op_rd),
      .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid),
      .writeback_value_o(wb_value), .writeback_rd_idx_o(wb_rd), .stall_o(stall));

   biriscv_mulf_unit #(.BITS_PER_CYCLE(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .opcode_valid_i(op_valid), .opcode_opcode_i(op_inst),
      .opcode_ra_operand_i(op_ra), .opcode_rb_operand_i(op_rb), .opcode_rd_idx_i(op_rd),
      .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid1),
      .writeback_value_o(wb_value1), .writeback_rd_idx_o(wb_rd1), .stall_o(stall1));

   biriscv_mulf_unit #(.BITS_PER_CYCLE(8)) dut8 (
      .clk_i(clk), .rst_i(rst), .opcode_valid_i(op_valid), .opcode_opcode_i(op_inst),
      .opcode_ra_operand_i(op_ra), .opcode_rb_operand_i(op_rb), .opcode_rd_idx_i(op_rd),
      .hold_i(hold), .flush_i(flush), .writeback_valid_o(wb_valid8),
      .writeback_value_o(wb_value8), .writeback_rd_idx_o(wb_rd8), .stall_o(stall8));

   biriscv_mulf_round_sat u_rs (.mag_i(rs_mag), .neg_i(rs_neg), .value_o(rs_value));

   // Reference: exact signed product, round magnitude half-up, re-sign, clamp.
   function automatic logic [31:0] ref_mulf(input logic [31:0] ra, input logic [31:0] rb);
      longint p, mag, r, v;
      p   = longint'(signed'(ra)) * longint'(signed'(rb));
      mag = (p < 0) ? -p : p;
      r   = (mag + 32768) / 65536;
      v   = (p < 0) ? -r : r;
      if (v > 64'sd2147483647)  v = 64'sd2147483647;
      if (v < -64'sd2147483648) v = -64'sd2147483648;
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_round_sat(input logic [63:0] mag, input logic neg);
      longint r, v;
      r = longint'((mag + 64'd32768) / 64'd65536);
      v = neg ? -r : r;
      if (v > 64'sd2147483647)  v = 64'sd2147483647;
      if (v < -64'sd2147483648) v = -64'sd2147483648;
      return v[31:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one instruction for one cycle; returns #1 after the accept edge.
   task automatic issue(input logic [31:0] inst, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [4:0] rd);
      op_valid = 1'b1;
      op_inst  = inst;
      op_ra    = ra;
      op_rb    = rb;
      op_rd    = rd;
      tick();
      op_valid = 1'b0;
   endtask

   // Latency counted in edges including the accept edge; 60 means never seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!wb_valid && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic expect_no_wb(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (wb_valid) seen++;
         tick();
      end
      check(name, seen, 0);
   endtask

   typedef struct {
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [63:0] mag;
      logic        neg;
      logic [31:0] exp;
   } rs_vec_t;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t    vecs[7];
      rs_vec_t rs_vecs[6];
      int lat, lat4, lat1, lat8, stall_bad;
      logic [31:0] val4, val1, val8, ra, rb, exp_v;
      logic [4:0]  rd4;
      logic        post_valid, post_stall;

      vecs[0] = '{32'h0001_8000, 32'h0002_0000, 32'h0003_0000};
      vecs[1] = '{32'hfffe_8000, 32'h0002_0000, 32'hfffd_0000};
      vecs[2] = '{32'h0000_0001, 32'h0000_8000, 32'h0000_0001};
      vecs[3] = '{32'hffff_ffff, 32'h0000_8000, 32'hffff_ffff};
      vecs[4] = '{32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff};
      vecs[5] = '{32'h8000_0000, 32'h7fff_ffff, 32'h8000_0000};
      vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h7fff_ffff};

      rs_vecs[0] = '{64'h0000_7fff_ffff_7fff, 1'b0, 32'h7fff_ffff};
      rs_vecs[1] = '{64'h0000_7fff_ffff_8000, 1'b0, 32'h7fff_ffff};
      rs_vecs[2] = '{64'h0000_7fff_ffff_8000, 1'b1, 32'h8000_0000};
      rs_vecs[3] = '{64'h0000_8000_0000_8000, 1'b1, 32'h8000_0000};
      rs_vecs[4] = '{64'h0000_0000_0000_7fff, 1'b1, 32'h0000_0000};
      rs_vecs[5] = '{64'h0000_0000_0000_8000, 1'b1, 32'hffff_ffff};

      rst = 1'b1; op_valid = 1'b0; op_inst = '0; op_ra = '0; op_rb = '0; op_rd = '0;
      hold = 1'b0; flush = 1'b0; rs_mag = '0; rs_neg = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_valid", wb_valid, 0);
      check("reset_value", wb_value, 0);
      check("reset_rd", wb_rd, 0);
      check("reset_stall", stall, 0);

      // Basic product on all three widths together.
      issue(INST_MULF, 32'h0001_8000, 32'h0002_0000, 5'd5);
      lat4 = 0; lat1 = 0; lat8 = 0; stall_bad = 0;
      val4 = '0; val1 = '0; val8 = '0; rd4 = '0; post_valid = 1'b1; post_stall = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) tick();
         if (lat4 != 0 && k == lat4 + 1) begin post_valid = wb_valid; post_stall = stall; end
         if (wb_valid && lat4 == 0) begin lat4 = k; val4 = wb_value; rd4 = wb_rd; end
         if (wb_valid1 && lat1 == 0) begin lat1 = k; val1 = wb_value1; end
         if (wb_valid8 && lat8 == 0) begin lat8 = k; val8 = wb_value8; end
         if ((lat4 == 0 || k == lat4) && !stall) stall_bad++;
      end
      check("basic_latency_bpc4", lat4, 9);
      check("basic_value_bpc4", val4, 32'h0003_0000);
      check("basic_rd_bpc4", rd4, 5);
      check("basic_stall_busy", stall_bad, 0);
      check("basic_done_exit_valid", post_valid, 0);
      check("basic_done_exit_stall", post_stall, 0);
      check("basic_latency_bpc1", lat1, 33);
      check("basic_value_bpc1", val1, 32'h0003_0000);
      check("basic_latency_bpc8", lat8, 5);
      check("basic_value_bpc8", val8, 32'h0003_0000);

      for (int i = 0; i < 7; i++) begin
         issue(INST_MULF, vecs[i].ra, vecs[i].rb, 5'(i + 10));
         wait_valid(lat);
         check($sformatf("vec%0d_latency", i), lat, 9);
         check($sformatf("vec%0d_value", i), wb_value, vecs[i].exp);
         check($sformatf("vec%0d_rd", i), wb_rd, i + 10);
         tick();
      end

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom_range(0, 32'h000f_ffff) - 32'h0008_0000;
                     rb = $urandom_range(0, 32'h000f_ffff) - 32'h0008_0000; end
            2: begin ra = $urandom_range(0, 32'h0000_ffff);
                     rb = $urandom_range(0, 1) ? 32'hffff_8000 : 32'h0000_8000; end
            default: begin ra = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7fff_ffff;
                     rb = $urandom_range(0, 32'h0003_ffff); end
         endcase
         exp_v = ref_mulf(ra, rb);
         issue(INST_MULF, ra, rb, 5'(i));
         wait_valid(lat);
         check($sformatf("rand%0d_latency", i), lat, 9);
         check($sformatf("rand%0d_value ra=%h rb=%h", i, ra, rb), wb_value, exp_v);
         check($sformatf("rand%0d_rd", i), wb_rd, i);
         tick();
      end

      // Hold for three edges after DONE entry, then back-to-back accept.
      issue(INST_MULF, 32'hfffe_8000, 32'h0002_0000, 5'd7);
      wait_valid(lat);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("hold%0d_valid_pre", i), wb_valid, 1);
         check($sformatf("hold%0d_value_pre", i), wb_value, 32'hfffd_0000);
         tick();
      end
      check("hold_valid_4th", wb_valid, 1);
      check("hold_rd_4th", wb_rd, 7);
      hold = 1'b0;
      tick();
      check("hold_release_valid", wb_valid, 0);
      check("hold_release_stall", stall, 0);
      issue(INST_MULF, 32'h0000_0001, 32'h0000_8000, 5'd8);
      check("b2b_accept_stall", stall, 1);
      wait_valid(lat);
      check("b2b_latency", lat, 9);
      check("b2b_value", wb_value, 32'h0000_0001);
      tick();

      // Flush in RUN discards the operation.
      issue(INST_MULF, 32'h0001_8000, 32'h0002_0000, 5'd9);
      repeat (2) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_run_stall", stall, 0);
      expect_no_wb("flush_run_no_wb", 12);

      // MULF alongside flush in IDLE is dropped.
      flush = 1'b1;
      issue(INST_MULF, 32'h0001_8000, 32'h0002_0000, 5'd9);
      flush = 1'b0;
      check("flush_idle_stall", stall, 0);
      expect_no_wb("flush_idle_no_wb", 12);

      // Flush beats hold in DONE.
      issue(INST_MULF, 32'h0001_8000, 32'h0002_0000, 5'd9);
      wait_valid(lat);
      hold = 1'b1;
      flush = 1'b1;
      tick();
      hold = 1'b0;
      flush = 1'b0;
      check("flush_done_valid", wb_valid, 0);
      check("flush_done_stall", stall, 0);

      // Reset mid-RUN.
      issue(INST_MULF, 32'h0001_8000, 32'h0002_0000, 5'd3);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_run_valid", wb_valid, 0);
      check("rst_run_value", wb_value, 0);
      check("rst_run_rd", wb_rd, 0);
      check("rst_run_stall", stall, 0);
      expect_no_wb("rst_run_no_wb", 12);

      // Non-MULF opcode is ignored.
      issue(INST_ADD, 32'h0001_8000, 32'h0002_0000, 5'd4);
      check("add_stall", stall, 0);
      expect_no_wb("add_no_wb", 12);

      for (int i = 0; i < 6; i++) begin
         rs_mag = rs_vecs[i].mag;
         rs_neg = rs_vecs[i].neg;
         #1;
         check($sformatf("rs_vec%0d", i), rs_value, rs_vecs[i].exp);
      end
      for (int i = 0; i < 200; i++) begin
         rs_mag = {$urandom, $urandom} >> $urandom_range(2, 63);
         rs_neg = 1'($urandom_range(0, 1));
         #1;
         check($sformatf("rs_rand mag=%h neg=%0d", rs_mag, rs_neg), rs_value,
               ref_round_sat(rs_mag, rs_neg));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
